// File: rtl/carrega_programa.sv
// carrega_programa: copies a process image from the HD into that process's
// instruction-memory partition, one word every two cycles.
module carrega_programa #(
  parameter int TAM_PARTICAO = 50,
  parameter int LARG_ENDER   = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inicio,
  input  logic [3:0]            trilha,
  input  logic [1:0]            id_proc,
  input  logic [5:0]            n_palavras,
  output logic [3:0]            hd_trilha,
  output logic [5:0]            hd_setor,
  input  logic [31:0]           hd_dado,
  output logic [LARG_ENDER-1:0] mi_ender,
  output logic [31:0]           mi_dado,
  output logic                  mi_we,
  output logic                  ocupado,
  output logic                  concluido
);

  typedef enum logic [1:0] {
    OCIOSO,
    LEITURA,
    ESCRITA,
    FIM
  } estado_t;

  estado_t               estado, proximo;
  logic [5:0]            n_reg;
  logic [5:0]            k;
  logic [5:0]            n_limitado;
  logic [LARG_ENDER-1:0] ender;
  logic [LARG_ENDER-1:0] base;
  logic [3:0]            trilha_reg;
  logic [5:0]            setor_reg;
  logic                  ultima;

  // Clamp the requested length to one partition and form the partition base.
  always_comb begin
    n_limitado = (int'(n_palavras) > TAM_PARTICAO) ? 6'(TAM_PARTICAO) : n_palavras;
    base       = LARG_ENDER'(int'(id_proc) * TAM_PARTICAO);
    ultima     = ((k + 6'd1) == n_reg);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) estado <= OCIOSO;
    else       estado <= proximo;
  end

  // Next-state decode.
  always_comb begin
    proximo = estado;
    unique case (estado)
      OCIOSO:  if (inicio) proximo = (n_limitado != 6'd0) ? LEITURA : FIM;
      LEITURA: proximo = ESCRITA;
      ESCRITA: proximo = ultima ? FIM : LEITURA;
      FIM:     proximo = OCIOSO;
      default: proximo = OCIOSO;
    endcase
  end

  // Datapath: captured parameters, word index, write address and HD address.
  // The sector register advances only when another read follows, so it
  // stops at the last sector read instead of running to N.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_reg      <= '0;
      k          <= '0;
      ender      <= '0;
      trilha_reg <= '0;
      setor_reg  <= '0;
    end else begin
      unique case (estado)
        OCIOSO: begin
          if (inicio) begin
            n_reg <= n_limitado;
            k     <= '0;
            ender <= base;
            if (n_limitado != 6'd0) begin
              trilha_reg <= trilha;
              setor_reg  <= '0;
            end
          end
        end
        ESCRITA: begin
          k     <= k + 6'd1;
          ender <= ender + LARG_ENDER'(1);
          if (!ultima) setor_reg <= k + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state; data is a gated pass-through.
  always_comb begin
    hd_trilha = trilha_reg;
    hd_setor  = setor_reg;
    mi_ender  = ender;
    mi_we     = (estado == ESCRITA);
    mi_dado   = (estado == ESCRITA) ? hd_dado : '0;
    ocupado   = (estado == LEITURA) || (estado == ESCRITA);
    concluido = (estado == FIM);
  end

endmodule

// File: tb/tb_carrega_programa.sv
// Directed bench for carrega_programa with a one-cycle-latency HD model.
module tb_carrega_programa;

  logic        clk = 1'b0;
  logic        reset;
  logic        inicio;
  logic [3:0]  trilha;
  logic [1:0]  id_proc;
  logic [5:0]  n_palavras;
  logic [3:0]  hd_trilha;
  logic [5:0]  hd_setor;
  logic [31:0] hd_dado = 32'hDEAD_BEEF;
  logic [8:0]  mi_ender;
  logic [31:0] mi_dado;
  logic        mi_we;
  logic        ocupado;
  logic        concluido;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          conc_count = 0;
  int          consec_cnt = 0;
  logic        prev_we    = 1'b0;

  carrega_programa #(.TAM_PARTICAO(50), .LARG_ENDER(9)) dut (
    .clk        (clk),
    .reset      (reset),
    .inicio     (inicio),
    .trilha     (trilha),
    .id_proc    (id_proc),
    .n_palavras (n_palavras),
    .hd_trilha  (hd_trilha),
    .hd_setor   (hd_setor),
    .hd_dado    (hd_dado),
    .mi_ender   (mi_ender),
    .mi_dado    (mi_dado),
    .mi_we      (mi_we),
    .ocupado    (ocupado),
    .concluido  (concluido)
  );

  always #5 clk = ~clk;

  // HD model (data valid one clock after the address) and write monitor.
  always @(posedge clk) begin
    hd_dado <= 32'hA000_0000 + {26'd0, hd_setor};
    if (mi_we) begin
      wr_addr.push_back({23'd0, mi_ender});
      wr_data.push_back(mi_dado);
    end
    if (concluido) conc_count++;
    if (mi_we && prev_we) consec_cnt++;
    prev_we = mi_we;
  end

  task automatic start_load(input logic [3:0] t, input logic [1:0] id, input logic [5:0] n);
    @(negedge clk);
    inicio = 1'b1; trilha = t; id_proc = id; n_palavras = n;
    @(negedge clk);
    inicio = 1'b0; trilha = 4'hF; id_proc = 2'd3; n_palavras = 6'd7;
  endtask

  task automatic test_reset;
    reset = 1'b1; inicio = 1'b0; trilha = 4'h0; id_proc = 2'd0; n_palavras = 6'd0;
    repeat (3) @(negedge clk);
    n_checks++; if (hd_trilha !== 4'd0)  begin n_fail++; $display("FAIL reset_hd_trilha: got %0d, expected 0", hd_trilha); end
    n_checks++; if (hd_setor !== 6'd0)   begin n_fail++; $display("FAIL reset_hd_setor: got %0d, expected 0", hd_setor); end
    n_checks++; if (mi_ender !== 9'd0)   begin n_fail++; $display("FAIL reset_mi_ender: got %0d, expected 0", mi_ender); end
    n_checks++; if (mi_dado !== 32'd0)   begin n_fail++; $display("FAIL reset_mi_dado: got %h, expected 0", mi_dado); end
    n_checks++; if (mi_we !== 1'b0)      begin n_fail++; $display("FAIL reset_mi_we: got %b, expected 0", mi_we); end
    n_checks++; if (ocupado !== 1'b0)    begin n_fail++; $display("FAIL reset_ocupado: got %b, expected 0", ocupado); end
    n_checks++; if (concluido !== 1'b0)  begin n_fail++; $display("FAIL reset_concluido: got %b, expected 0", concluido); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int w0 = wr_addr.size();
    int c0 = conc_count;
    start_load(4'd3, 2'd1, 6'd4);
    n_checks++; if (hd_trilha !== 4'd3) begin n_fail++; $display("FAIL basic_hd_trilha: got %0d, expected 3", hd_trilha); end
    n_checks++; if (hd_setor !== 6'd0)  begin n_fail++; $display("FAIL basic_hd_setor: got %0d, expected 0", hd_setor); end
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (concluido !== (i == 8)) begin n_fail++; $display("FAIL basic_concluido cycle %0d: got %b, expected %b", i, concluido, (i == 8)); end
      n_checks++;
      if (ocupado !== (i < 8)) begin n_fail++; $display("FAIL basic_ocupado cycle %0d: got %b, expected %b", i, ocupado, (i < 8)); end
      @(negedge clk);
    end
    n_checks++;
    if (wr_addr.size() !== w0 + 4) begin n_fail++; $display("FAIL basic_nwrites: got %0d, expected 4", wr_addr.size() - w0); end
    else for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (wr_addr[w0+j] !== 32'(50 + j)) begin n_fail++; $display("FAIL basic_addr[%0d]: got %0d, expected %0d", j, wr_addr[w0+j], 50 + j); end
      n_checks++;
      if (wr_data[w0+j] !== 32'hA000_0000 + 32'(j)) begin n_fail++; $display("FAIL basic_data[%0d]: got %h, expected %h", j, wr_data[w0+j], 32'hA000_0000 + 32'(j)); end
    end
    n_checks++;
    if (conc_count - c0 !== 1) begin n_fail++; $display("FAIL basic_npulses: got %0d, expected 1", conc_count - c0); end
  endtask

  task automatic test_zero;
    int w0 = wr_addr.size();
    start_load(4'd5, 2'd2, 6'd0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (concluido !== (i == 0)) begin n_fail++; $display("FAIL zero_concluido cycle %0d: got %b, expected %b", i, concluido, (i == 0)); end
      n_checks++;
      if (ocupado !== 1'b0) begin n_fail++; $display("FAIL zero_ocupado cycle %0d: got %b, expected 0", i, ocupado); end
      @(negedge clk);
    end
    n_checks++;
    if (wr_addr.size() !== w0) begin n_fail++; $display("FAIL zero_nwrites: got %0d, expected 0", wr_addr.size() - w0); end
  endtask

  task automatic test_clamp;
    int w0 = wr_addr.size();
    int done_at = -1;
    int max_setor = 0;
    start_load(4'd7, 2'd2, 6'd63);
    for (int i = 0; i < 200; i++) begin
      if (int'(hd_setor) > max_setor) max_setor = int'(hd_setor);
      if (concluido) begin done_at = i; break; end
      @(negedge clk);
    end
    n_checks++;
    if (done_at !== 100) begin n_fail++; $display("FAIL clamp_done_cycle: got %0d, expected 100", done_at); end
    n_checks++;
    if (max_setor !== 49) begin n_fail++; $display("FAIL clamp_max_setor: got %0d, expected 49", max_setor); end
    n_checks++;
    if (wr_addr.size() !== w0 + 50) begin n_fail++; $display("FAIL clamp_nwrites: got %0d, expected 50", wr_addr.size() - w0); end
    else for (int j = 0; j < 50; j++) begin
      n_checks++;
      if (wr_addr[w0+j] !== 32'(100 + j)) begin n_fail++; $display("FAIL clamp_addr[%0d]: got %0d, expected %0d", j, wr_addr[w0+j], 100 + j); end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_busy;
    int w0 = wr_addr.size();
    int c0 = conc_count;
    start_load(4'd5, 2'd1, 6'd3);
    for (int i = 0; i < 12; i++) begin
      if (i == 2) begin inicio = 1'b1; trilha = 4'd9; id_proc = 2'd3; n_palavras = 6'd1; end
      if (i == 3) inicio = 1'b0;
      if (i < 6) begin
        n_checks++;
        if (hd_trilha !== 4'd5) begin n_fail++; $display("FAIL busy_hd_trilha cycle %0d: got %0d, expected 5", i, hd_trilha); end
      end
      n_checks++;
      if (concluido !== (i == 6)) begin n_fail++; $display("FAIL busy_concluido cycle %0d: got %b, expected %b", i, concluido, (i == 6)); end
      @(negedge clk);
    end
    n_checks++;
    if (wr_addr.size() !== w0 + 3) begin n_fail++; $display("FAIL busy_nwrites: got %0d, expected 3", wr_addr.size() - w0); end
    else for (int j = 0; j < 3; j++) begin
      n_checks++;
      if (wr_addr[w0+j] !== 32'(50 + j)) begin n_fail++; $display("FAIL busy_addr[%0d]: got %0d, expected %0d", j, wr_addr[w0+j], 50 + j); end
    end
    n_checks++;
    if (conc_count - c0 !== 1) begin n_fail++; $display("FAIL busy_npulses: got %0d, expected 1", conc_count - c0); end
  endtask

  task automatic test_reset_mid;
    int w0 = wr_addr.size();
    int c0 = conc_count;
    bit reached = 1'b0;
    start_load(4'd2, 2'd1, 6'd5);
    for (int i = 0; i < 20; i++) begin
      if (wr_addr.size() == w0 + 2) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!reached) begin n_fail++; $display("FAIL midreset_two_writes: got %0d writes, expected 2", wr_addr.size() - w0); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (hd_trilha !== 4'd0) begin n_fail++; $display("FAIL midreset_hd_trilha: got %0d, expected 0", hd_trilha); end
    n_checks++; if (hd_setor !== 6'd0)  begin n_fail++; $display("FAIL midreset_hd_setor: got %0d, expected 0", hd_setor); end
    n_checks++; if (mi_ender !== 9'd0)  begin n_fail++; $display("FAIL midreset_mi_ender: got %0d, expected 0", mi_ender); end
    n_checks++; if (mi_dado !== 32'd0)  begin n_fail++; $display("FAIL midreset_mi_dado: got %h, expected 0", mi_dado); end
    n_checks++; if (mi_we !== 1'b0)     begin n_fail++; $display("FAIL midreset_mi_we: got %b, expected 0", mi_we); end
    n_checks++; if (ocupado !== 1'b0)   begin n_fail++; $display("FAIL midreset_ocupado: got %b, expected 0", ocupado); end
    n_checks++; if (concluido !== 1'b0) begin n_fail++; $display("FAIL midreset_concluido: got %b, expected 0", concluido); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (wr_addr.size() !== w0 + 2) begin n_fail++; $display("FAIL midreset_nwrites: got %0d, expected 2", wr_addr.size() - w0); end
    n_checks++;
    if (conc_count !== c0) begin n_fail++; $display("FAIL midreset_npulses: got %0d, expected 0", conc_count - c0); end
    w0 = wr_addr.size();
    c0 = conc_count;
    start_load(4'd1, 2'd3, 6'd2);
    repeat (8) @(negedge clk);
    n_checks++;
    if (wr_addr.size() !== w0 + 2) begin n_fail++; $display("FAIL fresh_nwrites: got %0d, expected 2", wr_addr.size() - w0); end
    else for (int j = 0; j < 2; j++) begin
      n_checks++;
      if (wr_addr[w0+j] !== 32'(150 + j)) begin n_fail++; $display("FAIL fresh_addr[%0d]: got %0d, expected %0d", j, wr_addr[w0+j], 150 + j); end
      n_checks++;
      if (wr_data[w0+j] !== 32'hA000_0000 + 32'(j)) begin n_fail++; $display("FAIL fresh_data[%0d]: got %h, expected %h", j, wr_data[w0+j], 32'hA000_0000 + 32'(j)); end
    end
    n_checks++;
    if (conc_count - c0 !== 1) begin n_fail++; $display("FAIL fresh_npulses: got %0d, expected 1", conc_count - c0); end
  endtask

  task automatic test_os_partition;
    int w0 = wr_addr.size();
    int k0 = consec_cnt;
    start_load(4'd4, 2'd0, 6'd2);
    repeat (8) @(negedge clk);
    n_checks++;
    if (wr_addr.size() !== w0 + 2) begin n_fail++; $display("FAIL os_nwrites: got %0d, expected 2", wr_addr.size() - w0); end
    else for (int j = 0; j < 2; j++) begin
      n_checks++;
      if (wr_addr[w0+j] !== 32'(j)) begin n_fail++; $display("FAIL os_addr[%0d]: got %0d, expected %0d", j, wr_addr[w0+j], j); end
    end
    n_checks++;
    if (consec_cnt !== k0) begin n_fail++; $display("FAIL os_consecutive_we: got %0d, expected 0", consec_cnt - k0); end
    n_checks++;
    if (consec_cnt !== 0) begin n_fail++; $display("FAIL any_consecutive_we: got %0d, expected 0", consec_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_clamp();
    test_busy();
    test_reset_mid();
    test_os_partition();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
